kbd_scan_decoder: RTL and testbench

Downstream stage of the `ps2` receiver. It consumes completed scan-code bytes and folds the Set-2 prefix bytes (E0 extended, F0 break, optionally E1 pause) into single key events. Events carry {code, ext, brk} and are buffered in a small FIFO behind a valid/ready handshake. It sits between the PS/2 receiver and the key-mapping/display logic.

---
 rtl/kbd_pkg.sv | 31 +++
 rtl/kbd_scan_decoder_fifo.sv | 42 ++++
 rtl/kbd_scan_decoder.sv | 89 ++++++++
 tb/tb_kbd_scan_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants, prefix FSM states and event type for the Set-2 scan decoder.
// KBD_PAUSE_SEQ_EN adds the PAUSE state used for the E1 pause sequence.
package kbd_pkg;
  localparam logic [7:0] KBD_PFX_EXT = 8'hE0;
  localparam logic [7:0] KBD_PFX_BRK = 8'hF0;
  localparam logic [7:0] KBD_PFX_PAUSE = 8'hE1;
  localparam logic [7:0] KBD_DISC_NUL = 8'h00;
  localparam logic [7:0] KBD_DISC_BAT = 8'hAA;
  localparam logic [7:0] KBD_DISC_ACK = 8'hFA;
  localparam logic [7:0] KBD_DISC_RESEND = 8'hFE;
  localparam logic [7:0] KBD_DISC_ERR = 8'hFF;
  localparam logic [7:0] KBD_PAUSE_CODE = 8'h77;
  localparam logic [2:0] KBD_PAUSE_SKIP = 3'd7;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
`ifdef KBD_PAUSE_SEQ_EN
    , ST_PAUSE
`endif
  } kbd_state_t;
  typedef struct packed {
    logic [7:0] code;
    logic ext;
    logic brk;
  } kbd_evt_t;
  function automatic logic kbd_is_discard(input logic [7:0] b);
    return b inside {KBD_DISC_NUL, KBD_DISC_BAT, KBD_DISC_ACK, KBD_DISC_RESEND, KBD_DISC_ERR};
  endfunction
endpackage

// File: rtl/kbd_scan_decoder_fifo.sv
// kbd_evt_fifo: event FIFO with registered head, wrap-bit pointers and a sticky overflow flag.
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  kbd_evt_t din,
  input  logic     ready,
  output logic     valid,
  output kbd_evt_t head,
  output logic     ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  kbd_evt_t mem [FIFO_DEPTH];
  logic [AW:0] rd_q, wr_q, rd_d;
  logic pop, full, accept;
  assign valid = rd_q != wr_q;
  assign pop = valid && ready;
  assign full = (rd_q ^ wr_q) == {1'b1, {AW{1'b0}}};
  assign accept = push && (!full || pop);
  assign rd_d = rd_q + (AW + 1)'(pop);
  always_ff @(posedge clk) begin
    if (accept) mem[wr_q[AW-1:0]] <= din;
  end
  // Head looks ahead to the post-pop read pointer; an empty FIFO forwards the incoming push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      head <= '0;
      ovf <= 1'b0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_q + (AW + 1)'(accept);
      head <= (rd_d != wr_q) ? mem[rd_d[AW-1:0]] : accept ? din : head;
      ovf <= ovf | (push && !accept);
    end
  end
endmodule

// File: rtl/kbd_scan_decoder.sv
// kbd_scan_decoder: folds Set-2 E0/F0 prefixes into key events queued behind valid/ready.
// Define KBD_PAUSE_SEQ_EN to collapse the E1 pause sequence into a single event.
module kbd_scan_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       ovf
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  kbd_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push;
  kbd_evt_t evt, head;
`ifdef KBD_PAUSE_SEQ_EN
  logic [2:0] skip_q, skip_d;
`endif
  always_comb begin
    state_d = state_q;
    push = 1'b0;
    evt = '{code: rx_data, ext: state_q inside {ST_EXT, ST_EXT_BRK}, brk: state_q inside {ST_BRK, ST_EXT_BRK}};
    cnt_d = (rx_valid || state_q == ST_IDLE) ? '0 : cnt_q + 1'b1;
`ifdef KBD_PAUSE_SEQ_EN
    skip_d = skip_q;
`endif
    if (!rx_valid)
      state_d = (state_q != ST_IDLE && cnt_q == CW'(TIMEOUT_CYC - 1)) ? ST_IDLE : state_q;
`ifdef KBD_PAUSE_SEQ_EN
    else if (state_q == ST_PAUSE) begin
      skip_d = skip_q - 1'b1;
      push = skip_q == 3'd1;
      evt = '{code: KBD_PAUSE_CODE, ext: 1'b1, brk: 1'b0};
      state_d = (skip_q == 3'd1) ? ST_IDLE : ST_PAUSE;
    end
`endif
    else if (rx_data == KBD_PFX_EXT)
      state_d = (state_q inside {ST_BRK, ST_EXT_BRK}) ? ST_EXT_BRK : ST_EXT;
    else if (rx_data == KBD_PFX_BRK)
      state_d = (state_q inside {ST_EXT, ST_EXT_BRK}) ? ST_EXT_BRK : ST_BRK;
`ifdef KBD_PAUSE_SEQ_EN
    else if (rx_data == KBD_PFX_PAUSE && state_q == ST_IDLE) begin
      state_d = ST_PAUSE;
      skip_d = KBD_PAUSE_SKIP;
    end
`endif
    else begin
      push = !(kbd_is_discard(rx_data) || rx_data == KBD_PFX_PAUSE);
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef KBD_PAUSE_SEQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skip_q <= '0;
    else skip_q <= skip_d;
  end
`endif
  kbd_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (evt),
    .ready(evt_ready),
    .valid(evt_valid),
    .head (head),
    .ovf  (ovf)
  );
  assign evt_code = head.code;
  assign evt_ext = head.ext;
  assign evt_brk = head.brk;
endmodule

// File: tb/tb_kbd_scan_decoder.sv
// tb_kbd_scan_decoder: directed stimulus, per-cycle comparison against a prefix/queue model,
// plus literal checks of the accepted-event log.
module tb_kbd_scan_decoder;
  localparam int DEPTH = 4;
  localparam int TO = 60;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] rx_data;
  logic rx_valid;
  logic evt_valid, evt_ready, evt_ext, evt_brk, ovf;
  logic [7:0] evt_code;
  int checks = 0;
  int errors = 0;
  logic [9:0] mq[$];
  logic [9:0] got[$];
  bit m_ext, m_brk, m_ovf;
  int m_pause, m_idle;

  always #5 clk = ~clk;

  kbd_scan_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_brk(evt_brk), .ovf(ovf)
  );

  // Model: prefix flags, a pause skip count and an idle counter feed a bounded event queue.
  initial forever begin
    logic [9:0] e;
    bit have;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_pause = 0; m_idle = 0;
    end else begin
      have = 0;
      e = '0;
      if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
      if (rx_valid) begin
        m_idle = 0;
        if (m_pause > 0) begin
          m_pause--;
          if (m_pause == 0) begin have = 1; e = {8'h77, 1'b1, 1'b0}; end
        end else begin
          case (rx_data)
            8'hE0: m_ext = 1;
            8'hF0: m_brk = 1;
            8'hE1: begin
`ifdef KBD_PAUSE_SEQ_EN
              m_pause = (!m_ext && !m_brk) ? 7 : 0;
`endif
              m_ext = 0; m_brk = 0;
            end
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: begin m_ext = 0; m_brk = 0; end
            default: begin
              have = 1; e = {rx_data, m_ext, m_brk};
              m_ext = 0; m_brk = 0;
            end
          endcase
        end
      end else if (m_ext || m_brk || m_pause > 0) begin
        m_idle++;
        if (m_idle == TO) begin m_ext = 0; m_brk = 0; m_pause = 0; m_idle = 0; end
      end
      if (have) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1;
      end
    end
  end

  initial forever begin
    logic exp_v;
    @(negedge clk);
    if (rst_n === 1'b1) begin
      exp_v = mq.size() > 0;
      checks++;
      if (evt_valid !== exp_v || ovf !== m_ovf || (exp_v && {evt_code, evt_ext, evt_brk} !== mq[0])) begin
        errors++;
        $display("FAIL model t=%0t valid=%b head=%h ovf=%b required valid=%b head=%h ovf=%b",
                 $time, evt_valid, {evt_code, evt_ext, evt_brk}, ovf, exp_v,
                 exp_v ? mq[0] : 10'h0, m_ovf);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && evt_valid && evt_ready) got.push_back({evt_code, evt_ext, evt_brk});
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk_got(input string nm, input int i, input logic [9:0] e);
    checks++;
    if (i >= got.size()) begin
      errors++;
      $display("FAIL %s got no event %0d required %h", nm, i, e);
    end else if (got[i] !== e) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got[i], e);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rx_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; evt_ready = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_code", 32'(evt_code), 0);
    chk("rst_ext_brk", 32'({evt_ext, evt_brk}), 0);
    chk("rst_ovf", 32'(ovf), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    got.delete();
    send(8'h1C);
    @(negedge clk) chk("lat_n", 32'(evt_valid), 0);
    idle(1);
    @(negedge clk) chk("lat_n1", 32'({evt_valid, evt_code, evt_ext, evt_brk}), {1'b1, 8'h1C, 2'b00});
    @(negedge clk) chk("lat_n2", 32'(evt_valid), 0);
    idle(2);
    chk("make_n", 32'(got.size()), 1);
    got.delete();
    send(8'hE0); send(8'hF0); send(8'h6C); send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hE0); send(8'hF0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'hE0); send(8'h74); send(8'hE0); send(8'hAA); send(8'h1C);
    idle(4);
    chk("prefix_n", 32'(got.size()), 5);
    chk_got("ext_brk", 0, {8'h6C, 2'b11});
    chk_got("brk", 1, {8'h1C, 2'b01});
    chk_got("redundant", 2, {8'h75, 2'b11});
    chk_got("brk_then_ext", 3, {8'h74, 2'b11});
    chk_got("discard", 4, {8'h1C, 2'b00});
    got.delete();
    evt_ready = 1'b0;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    idle(2);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_hold", 32'({evt_valid, evt_code}), {1'b1, 8'h15});
    evt_ready = 1'b1;
    idle(6);
    chk("ovf_n", 32'(got.size()), 4);
    chk_got("ovf0", 0, {8'h15, 2'b00});
    chk_got("ovf1", 1, {8'h1D, 2'b00});
    chk_got("ovf2", 2, {8'h24, 2'b00});
    chk_got("ovf3", 3, {8'h2D, 2'b00});
    chk("ovf_sticky", 32'(ovf), 1);
    got.delete();
    send(8'hE0); idle(TO); send(8'h1C); idle(3);
    send(8'hE0); idle(TO - 1); send(8'h1C); idle(3);
    chk_got("timeout", 0, {8'h1C, 2'b00});
    chk_got("no_timeout", 1, {8'h1C, 2'b10});
    got.delete();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    idle(4);
`ifdef KBD_PAUSE_SEQ_EN
    chk("pause_n", 32'(got.size()), 1);
    chk_got("pause", 0, {8'h77, 2'b10});
`else
    chk("pause_n", 32'(got.size()), 4);
    chk_got("pause0", 0, {8'h14, 2'b00});
    chk_got("pause1", 1, {8'h77, 2'b00});
    chk_got("pause2", 2, {8'h14, 2'b01});
    chk_got("pause3", 3, {8'h77, 2'b01});
`endif
    send(8'hE0); send(8'hF0);
    #2 rst_n = 1'b0;
    rx_valid = 1'b0;
    #1 chk("async_rst", 32'({evt_valid, ovf}), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    got.delete();
    send(8'h6C); idle(3);
    chk("rst_seq_n", 32'(got.size()), 1);
    chk_got("rst_seq", 0, {8'h6C, 2'b00});
    chk("rst_ovf_clear", 32'(ovf), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
